simplez_seq: RTL
================

Name: simplez_seq

Overview:
- Control unit (sequencer) for the Simplez datapath: PC, RA, RI, AC, data/address buses and main memory.
- Decodes the 3-bit opcode and drives every microorder for the full 8-instruction set.
- Adds a memory-ready handshake and a single-step debug mode.
- Sits between the datapath and the top level; replaces the partial in-core sequencer.

Parameters:
- STEP_DEFAULT, 0, value of the internal step-mode enable after reset (1 = start paused).

Ports:
- clk  in  1  system clock; the state register updates on the falling edge, like the datapath registers.
- rst  in  1  reset, asynchronous, active-high.
- co  in  3  opcode from RI[11:9]: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- ac_zero  in  1  high when AC == 0.
- mem_rdy  in  1  memory access completes in this cycle.
- step_en  in  1  level; when high, the sequencer pauses before each fetch.
- step  in  1  one-cycle pulse; releases one instruction in step mode.
- lec, esc  out  1  memory read / write.
- era  out  1  load RA from busAi.
- incp, ecp, scp  out  1  increment PC / load PC from busAi / drive PC onto busAi.
- eri, sri  out  1  load RI from busD / drive CD onto busAi.
- eac, sac  out  1  load AC / drive AC onto busD.
- alu_op  out  2  0 = PASS busD, 1 = ADD, 2 = CLR, 3 = DEC.
- stop  out  1  processor halted.
- fetch  out  1  one-cycle pulse on each completed instruction fetch.
- state  out  3  debug: INI=0, I0=1, I1=2, O0=3, O1=4, HLT=5, PAUSE=6.

Behaviour:
- Reset
  - rst high → state = INI, step_pending = 0.
  - All outputs are forced to 0 while rst = 1, regardless of state.
- INI: scp, era (RA ← PC = 0). Next state is PAUSE if step_en, otherwise I0.
- PAUSE
  - All microorders are 0.
  - Go to I0 on the cycle step_pending or step is high; that cycle clears step_pending.
  - If step_en drops, go to I0 immediately.
- step_pending: set on a step pulse in any state other than PAUSE; cleared on leaving PAUSE. Multiple pulses collapse to one.
- I0 (fetch)
  - lec, eri asserted every cycle; the state holds until mem_rdy = 1.
  - incp and fetch are asserted only in the mem_rdy cycle; next state I1.
  - eri may be asserted early; RI re-latches each cycle and the final value is the mem_rdy data.
- I1 (decode), one cycle:
  - ST/LD/ADD: sri, era → O0.
  - BR: sri, ecp, era → I0/PAUSE.
  - BZ with ac_zero = 1: same as BR.
  - BZ with ac_zero = 0: scp, era → I0/PAUSE.
  - CLR: eac, alu_op = 2, scp, era → I0/PAUSE.
  - DEC: eac, alu_op = 3, scp, era → I0/PAUSE. AC wraps 0 → 0xFFF; the wrap is handled in the datapath and is not checked here.
  - HALT: stop = 1 → HLT.
- "I0/PAUSE" means PAUSE if step_en = 1, otherwise I0.
- O0 (operand)
  - ST: sac, esc held until mem_rdy.
  - LD: lec held; eac with alu_op = 0 only in the mem_rdy cycle.
  - ADD: lec held; eac with alu_op = 1 only in the mem_rdy cycle.
  - Leave O0 → O1 on mem_rdy.
- O1: scp, era → I0/PAUSE.
- HLT
  - stop = 1; all other outputs 0.
  - Stays in HLT until reset; step and step_en are ignored.
- Exclusivity rules:
  - At most one of scp/sri is high in any cycle.
  - At most one of sac/lec is high in any cycle.
  - incp and ecp are never high together.
  - esc is never high outside O0.
- Reset mid-instruction (any state, including inside a mem_rdy wait) → INI on the next active edge after rst falls. No partial write: esc drops asynchronously with rst.
- Illegal state encodings recover to INI.
- Latency (mem_rdy tied high):
  - ST/LD/ADD: 4 cycles (I0, I1, O0, O1).
  - BR/BZ/CLR/DEC: 2 cycles.
  - HALT: 2 cycles to reach HLT.

Test Plan:
1. Reset, mem_rdy = 1, co = LD → states 0,1,2,3,4,1. Check era/scp in INI; incp/fetch at cycle 1; sri/era at cycle 2; lec/eac with alu_op = 0 at cycle 3.
2. mem_rdy low for 3 cycles in I0, then high → state stays I0 for 4 cycles; lec/eri held throughout; incp and fetch appear only once, in the 4th cycle.
3. co = BZ with ac_zero = 0, then again with ac_zero = 1 → first: scp/era and no ecp; second: sri/ecp/era. Both return to I0 after one cycle.
4. co = ST with mem_rdy delayed 2 cycles in O0 → sac/esc high for 3 cycles; no lec; then O1 with scp/era.
5. step_en = 1 → after INI, PAUSE holds for 10 cycles with all outputs 0. A single step pulse runs exactly one instruction (co = CLR: eac with alu_op = 2) and the sequencer returns to PAUSE.
6. co = HALT → stop = 1 and state = 5 permanently; step ignored. Assert rst during the O0 esc wait of a later ST → esc = 0 immediately; state = 0 after release.

Source files
------------

// File: rtl/simplez_seq.sv
// simplez_seq - control unit for the Simplez datapath.
//
// Decodes the 3-bit opcode held in RI and issues every microorder for the
// eight-instruction set. It waits on a memory-ready handshake and supports
// single-step debugging.
//
// Ports:
//   clk           system clock; the state register updates on the falling
//                 edge, like the datapath registers
//   rst           asynchronous active-high reset
//   co[2:0]       opcode from RI[11:9]
//   ac_zero       AC == 0
//   mem_rdy       memory access completes this cycle
//   step_en       step mode: pause before each fetch
//   step          one-cycle pulse that releases one instruction
//   lec/esc       memory read / write
//   era           load RA from busAi
//   incp/ecp/scp  increment PC / load PC / drive PC onto busAi
//   eri/sri       load RI / drive CD onto busAi
//   eac/sac       load AC / drive AC onto busD
//   alu_op[1:0]   0 PASS, 1 ADD, 2 CLR, 3 DEC
//   stop          processor halted
//   fetch         pulse on each completed instruction fetch
//   state[2:0]    debug view of the sequencer state
module simplez_seq #(
  parameter bit STEP_DEFAULT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] co,
  input  logic       ac_zero,
  input  logic       mem_rdy,
  input  logic       step_en,
  input  logic       step,
  output logic       lec,
  output logic       esc,
  output logic       era,
  output logic       incp,
  output logic       ecp,
  output logic       scp,
  output logic       eri,
  output logic       sri,
  output logic       eac,
  output logic       sac,
  output logic [1:0] alu_op,
  output logic       stop,
  output logic       fetch,
  output logic [2:0] state
);

  localparam logic [2:0] S_INI   = 3'd0;
  localparam logic [2:0] S_I0    = 3'd1;
  localparam logic [2:0] S_I1    = 3'd2;
  localparam logic [2:0] S_O0    = 3'd3;
  localparam logic [2:0] S_O1    = 3'd4;
  localparam logic [2:0] S_HLT   = 3'd5;
  localparam logic [2:0] S_PAUSE = 3'd6;

  localparam logic [2:0] OP_ST  = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_BR  = 3'd3;
  localparam logic [2:0] OP_BZ  = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  logic [2:0] r_state, w_next, w_after;
  logic       r_step_pend, r_step_hold;
  logic       w_step_mode, w_release;
  logic       w_lec, w_esc, w_era, w_incp, w_ecp, w_scp;
  logic       w_eri, w_sri, w_eac, w_sac, w_stop, w_fetch;
  logic [1:0] w_alu;

  // r_step_hold carries STEP_DEFAULT out of reset: the sequencer then starts
  // paused until the first release, even if the step_en pin is low.
  assign w_step_mode = step_en | r_step_hold;
  assign w_release   = !w_step_mode || r_step_pend || step;
  assign w_after     = w_step_mode ? S_PAUSE : S_I0;

  always_comb begin
    w_next = S_INI;
    case (r_state)
      S_INI:   w_next = w_after;
      S_PAUSE: w_next = w_release ? S_I0 : S_PAUSE;
      S_I0:    w_next = mem_rdy ? S_I1 : S_I0;
      S_I1: begin
        case (co)
          OP_ST, OP_LD, OP_ADD: w_next = S_O0;
          OP_HLT:               w_next = S_HLT;
          default:              w_next = w_after;
        endcase
      end
      S_O0:    w_next = mem_rdy ? S_O1 : S_O0;
      S_O1:    w_next = w_after;
      S_HLT:   w_next = S_HLT;
      default: w_next = S_INI;   // illegal encodings recover
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INI;
      r_step_pend <= 1'b0;
      r_step_hold <= STEP_DEFAULT;
    end else begin
      r_state <= w_next;
      // A pulse seen outside PAUSE is remembered so the next PAUSE releases
      // straight away; repeated pulses collapse into one.
      if (r_state == S_PAUSE) begin
        if (w_release) begin
          r_step_pend <= 1'b0;
          r_step_hold <= 1'b0;
        end
      end else if (r_state != S_HLT && step) begin
        r_step_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_lec = 1'b0; w_esc = 1'b0; w_era = 1'b0; w_incp = 1'b0;
    w_ecp = 1'b0; w_scp = 1'b0; w_eri = 1'b0; w_sri = 1'b0;
    w_eac = 1'b0; w_sac = 1'b0; w_stop = 1'b0; w_fetch = 1'b0;
    w_alu = 2'd0;
    case (r_state)
      S_INI: begin
        w_scp = 1'b1; w_era = 1'b1;
      end
      S_I0: begin
        // RI re-latches every wait cycle; the mem_rdy cycle's data wins.
        w_lec = 1'b1; w_eri = 1'b1;
        w_incp = mem_rdy; w_fetch = mem_rdy;
      end
      S_I1: begin
        case (co)
          OP_ST, OP_LD, OP_ADD: begin
            w_sri = 1'b1; w_era = 1'b1;
          end
          OP_BR: begin
            w_sri = 1'b1; w_ecp = 1'b1; w_era = 1'b1;
          end
          OP_BZ: begin
            w_sri = ac_zero; w_ecp = ac_zero; w_scp = !ac_zero; w_era = 1'b1;
          end
          OP_CLR: begin
            w_eac = 1'b1; w_alu = 2'd2; w_scp = 1'b1; w_era = 1'b1;
          end
          OP_DEC: begin
            w_eac = 1'b1; w_alu = 2'd3; w_scp = 1'b1; w_era = 1'b1;
          end
          default: w_stop = 1'b1;
        endcase
      end
      S_O0: begin
        case (co)
          OP_ST: begin
            w_sac = 1'b1; w_esc = 1'b1;
          end
          OP_LD: begin
            w_lec = 1'b1; w_eac = mem_rdy;
          end
          OP_ADD: begin
            w_lec = 1'b1; w_eac = mem_rdy; w_alu = mem_rdy ? 2'd1 : 2'd0;
          end
          default: ;
        endcase
      end
      S_O1: begin
        w_scp = 1'b1; w_era = 1'b1;
      end
      S_HLT:   w_stop = 1'b1;
      default: ;
    endcase
  end

  // Gating with rst drops esc the instant reset rises: no partial write.
  assign lec    = w_lec   & ~rst;
  assign esc    = w_esc   & ~rst;
  assign era    = w_era   & ~rst;
  assign incp   = w_incp  & ~rst;
  assign ecp    = w_ecp   & ~rst;
  assign scp    = w_scp   & ~rst;
  assign eri    = w_eri   & ~rst;
  assign sri    = w_sri   & ~rst;
  assign eac    = w_eac   & ~rst;
  assign sac    = w_sac   & ~rst;
  assign stop   = w_stop  & ~rst;
  assign fetch  = w_fetch & ~rst;
  assign alu_op = rst ? 2'd0 : w_alu;
  assign state  = rst ? S_INI : r_state;

endmodule
